// File: rtl/lcd_win_cap_if.sv
// Pixel capture / window read bus between the LCD controller side, the consumer and lcd_win_cap.
interface lcd_win_cap_if #(parameter int PIX_W = 8);
  logic [PIX_W-1:0] datain;
  logic             in_valid;
  logic             ctrl_busy;
  logic             rd_en;
  logic [3:0]       rd_addr;
  logic             frame_done;
  logic [PIX_W-1:0] rd_data;
  logic             frame_valid;
  logic [11:0]      pix_sum;
  logic [PIX_W-1:0] pix_max;
  logic [PIX_W-1:0] pix_min;
  logic             overflow;
  logic             frag_err;

  modport master (
    output datain, in_valid, ctrl_busy, rd_en, rd_addr, frame_done,
    input  rd_data, frame_valid, pix_sum, pix_max, pix_min, overflow, frag_err
  );

  modport slave (
    input  datain, in_valid, ctrl_busy, rd_en, rd_addr, frame_done,
    output rd_data, frame_valid, pix_sum, pix_max, pix_min, overflow, frag_err
  );
endinterface

// File: rtl/lcd_win_cap.sv
// Ping-pong 4x4 window capture: fills one bank from the LCD stream while the consumer
// reads the other, with per-bank sum/max/min stats, drop-on-full and fragment detection.
module lcd_win_cap #(
  parameter int PIX_W     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic         clk,
  input  logic         reset,
  lcd_win_cap_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DROP} wst_e;

  wst_e             st, st_nxt;
  logic [3:0]       wr_cnt;
  logic             wr_bank, rd_bank;
  logic [1:0]       full;
  logic             busy_q;
  logic [PIX_W-1:0] mem [2][FRAME_LEN];
  logic [11:0]      run_sum;
  logic [PIX_W-1:0] run_max, run_min;
  logic [1:0][11:0]      st_sum;
  logic [1:0][PIX_W-1:0] st_max, st_min;
  logic [PIX_W-1:0] rd_data_q;
  logic             ovf_q, frag_q;

  logic             acc, store, frag, done, ovf_set, last, first, fv, rel;
  logic [11:0]      nxt_sum;
  logic [PIX_W-1:0] nxt_max, nxt_min;

  assign last  = (wr_cnt == 4'(FRAME_LEN-1));
  assign first = (wr_cnt == 4'd0);
  assign fv    = full[rd_bank];
  assign rel   = bus.frame_done & fv;

  assign nxt_sum = first ? 12'(bus.datain) : run_sum + 12'(bus.datain);
  assign nxt_max = (first || bus.datain > run_max) ? bus.datain : run_max;
  assign nxt_min = (first || bus.datain < run_min) ? bus.datain : run_min;

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // The pixel that moves IDLE->FILL/DROP is itself accepted as index 0.
  always_comb begin
    st_nxt  = st;
    acc     = 1'b0;
    store   = 1'b0;
    done    = 1'b0;
    ovf_set = 1'b0;
    frag    = busy_q & ~bus.ctrl_busy & (st != IDLE) & (wr_cnt != 4'd0);
    if (frag) begin
      st_nxt = IDLE;
    end else if (bus.in_valid) begin
      acc = 1'b1;
      case (st)
        IDLE: begin
          if (full[wr_bank]) st_nxt = DROP;
          else begin
            store  = 1'b1;
            st_nxt = FILL;
          end
        end
        FILL:    store = 1'b1;
        default: ;
      endcase
      if (last) begin
        st_nxt  = IDLE;
        done    = store;
        ovf_set = ~store;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_bank][wr_cnt] <= bus.datain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      busy_q    <= 1'b0;
      run_sum   <= '0;
      run_max   <= '0;
      run_min   <= '0;
      st_sum    <= '0;
      st_max    <= '0;
      st_min    <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      frag_q    <= 1'b0;
    end else begin
      busy_q <= bus.ctrl_busy;
      if (frag) begin
        wr_cnt <= '0;
        frag_q <= 1'b1;
      end else if (acc) begin
        wr_cnt  <= last ? 4'd0 : wr_cnt + 4'd1;
        run_sum <= nxt_sum;
        run_max <= nxt_max;
        run_min <= nxt_min;
      end
      if (ovf_set) ovf_q <= 1'b1;
      // A completing write and a release always target different banks.
      if (done) begin
        full[wr_bank]   <= 1'b1;
        st_sum[wr_bank] <= nxt_sum;
        st_max[wr_bank] <= nxt_max;
        st_min[wr_bank] <= nxt_min;
        wr_bank         <= ~wr_bank;
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (bus.rd_en && fv) rd_data_q <= mem[rd_bank][bus.rd_addr];
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = fv;
  assign bus.pix_sum     = st_sum[rd_bank];
  assign bus.pix_max     = st_max[rd_bank];
  assign bus.pix_min     = st_min[rd_bank];
  assign bus.overflow    = ovf_q;
  assign bus.frag_err    = frag_q;
endmodule

// File: tb/tb_lcd_win_cap.sv
// Scoreboard bench for lcd_win_cap: frames driven from tables, read data checked via a queue.
module tb_lcd_win_cap;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_win_cap_if #(.PIX_W(8)) bus ();
  lcd_win_cap #(.PIX_W(8), .FRAME_LEN(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef logic [7:0] frm_t [16];

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q [$];
  logic [7:0] last_rd = 8'h00;
  frm_t       f1, f2, f3, fff, f4, f5, fa, fb, fc, fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mk_rand(output frm_t f);
    for (int i = 0; i < 16; i++) f[i] = 8'($urandom);
  endtask

  // Drive pixels lo..hi-1; optional idle gaps, optional frame_done on the last one.
  task automatic send(input frm_t f, input int lo, input int hi, input bit gaps, input bit done_last);
    for (int i = lo; i < hi; i++) begin
      bus.datain     = f[i];
      bus.in_valid   = 1'b1;
      bus.frame_done = done_last && (i == hi-1);
      step();
      bus.in_valid   = 1'b0;
      bus.frame_done = 1'b0;
      if (gaps && i[0]) step();
    end
  endtask

  task automatic rd_px(input logic [3:0] a, input logic [7:0] e);
    sb_q.push_back(e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    step();
    bus.rd_en = 1'b0;
    chk($sformatf("rd_data[%0d]", a), 32'(bus.rd_data), 32'(sb_q.pop_front()));
    last_rd = e;
  endtask

  task automatic chk_frame(input string tag, input frm_t f);
    int         s;
    logic [7:0] mx, mn;
    s = 0; mx = 8'h00; mn = 8'hff;
    for (int i = 0; i < 16; i++) begin
      s += int'(f[i]);
      if (f[i] > mx) mx = f[i];
      if (f[i] < mn) mn = f[i];
    end
    chk({tag, ".valid"}, 32'(bus.frame_valid), 32'd1);
    chk({tag, ".sum"},   32'(bus.pix_sum), 32'(s));
    chk({tag, ".max"},   32'(bus.pix_max), 32'(mx));
    chk({tag, ".min"},   32'(bus.pix_min), 32'(mn));
    rd_px(4'd0,  f[0]);
    rd_px(4'd5,  f[5]);
    rd_px(4'd15, f[15]);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, 32'(bus.frame_valid), 32'd0);
    chk({tag, ".rd"},    32'(bus.rd_data), 32'd0);
    chk({tag, ".sum"},   32'(bus.pix_sum), 32'd0);
    chk({tag, ".max"},   32'(bus.pix_max), 32'd0);
    chk({tag, ".min"},   32'(bus.pix_min), 32'd0);
    chk({tag, ".ovf"},   32'(bus.overflow), 32'd0);
    chk({tag, ".frag"},  32'(bus.frag_err), 32'd0);
  endtask

  task automatic release_frame();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
  endtask

  initial begin
    bus.datain = '0; bus.in_valid = 1'b0; bus.ctrl_busy = 1'b1;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.frame_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("rst");

    // Ramp 1..16: sum 136, addr 5 holds 0x06
    for (int i = 0; i < 16; i++) f1[i] = 8'(i + 1);
    send(f1, 0, 16, 1'b0, 1'b0);
    chk("ramp.sum", 32'(bus.pix_sum), 32'd136);
    chk_frame("f1", f1);

    // Second frame fills the other bank; third is dropped on its 16th pixel
    mk_rand(f2);
    send(f2, 0, 16, 1'b1, 1'b0);
    chk("ovf.after2", 32'(bus.overflow), 32'd0);
    mk_rand(f3);
    send(f3, 0, 15, 1'b0, 1'b0);
    chk("ovf.pre16", 32'(bus.overflow), 32'd0);
    send(f3, 15, 16, 1'b0, 1'b0);
    chk("ovf.post16", 32'(bus.overflow), 32'd1);
    chk_frame("f1.kept", f1);
    release_frame();
    chk_frame("f2", f2);
    release_frame();
    chk("empty.valid", 32'(bus.frame_valid), 32'd0);
    rd_px(4'd3, last_rd);
    release_frame();
    chk("ignored.valid", 32'(bus.frame_valid), 32'd0);

    // All-0xFF window: maximum sum
    for (int i = 0; i < 16; i++) fff[i] = 8'hff;
    send(fff, 0, 16, 1'b0, 1'b0);
    chk("ff.sum", 32'(bus.pix_sum), 32'd4080);
    chk_frame("ff", fff);
    release_frame();

    // Fragment: 7 pixels then busy falls
    mk_rand(f4);
    send(f4, 0, 7, 1'b0, 1'b0);
    bus.ctrl_busy = 1'b0;
    step();
    chk("frag.err", 32'(bus.frag_err), 32'd1);
    chk("frag.valid", 32'(bus.frame_valid), 32'd0);
    bus.ctrl_busy = 1'b1;
    step();
    mk_rand(f5);
    send(f5, 0, 16, 1'b0, 1'b0);
    chk_frame("f5", f5);
    release_frame();

    // Release coincides with completion of the next bank
    mk_rand(fa);
    send(fa, 0, 16, 1'b0, 1'b0);
    chk_frame("fa", fa);
    mk_rand(fb);
    send(fb, 0, 16, 1'b0, 1'b1);
    chk_frame("fb", fb);
    release_frame();

    // Reset mid-frame
    mk_rand(fc);
    send(fc, 0, 10, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("rst2");
    mk_rand(fd);
    send(fd, 0, 16, 1'b0, 1'b0);
    chk_frame("fd", fd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
